bias_seq_ctrl: RTL and testbench
================================

Name: bias_seq_ctrl

Overview:
Sequencer for the dual-port, 16-row x 128-bit bias ROM. Each ROM row packs eight signed 16-bit biases. On a start pulse it walks the ROM two rows per fetch, using port A for the even row and port B for the odd row. It unpacks the rows and streams biases one per handshake to the neuron accumulate stage, with valid/ready backpressure and a last flag.

Parameters:
ADDR_WIDTH, 4, ROM address width
DEPTH, 16, ROM rows
DATA_WIDTH, 128, ROM row width (8 lanes x 16 bits)
NUM_BIAS, 122, biases streamed per run (15 full rows + 2 lanes of row 15); legal range 0..8*DEPTH
IDX_WIDTH, 7, width of bias_idx

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins a run when idle
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse after the final handshake
rom_addr_a  out  ADDR_WIDTH  even-row address to ROM port A (registered)
rom_addr_b  out  ADDR_WIDTH  odd-row address to ROM port B (registered)
rom_q_a  in  DATA_WIDTH  ROM port A data; 1-cycle registered read
rom_q_b  in  DATA_WIDTH  ROM port B data; 1-cycle registered read
bias_data  out  16  signed bias word
bias_idx  out  IDX_WIDTH  index of bias_data, 0..NUM_BIAS-1
bias_valid  out  1  bias_data/bias_idx valid
bias_ready  in  1  consumer accepts when high with bias_valid
bias_last  out  1  high with the word whose index is NUM_BIAS-1

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: all outputs 0, including both addresses, busy, done, bias_valid, bias_last, bias_data and bias_idx. State is IDLE.
- Reset mid-run aborts immediately. No done pulse is produced.
- Bias mapping:
  - Bias i is in row i/8.
  - Lane 0 is bits [127:112] and lane 7 is bits [15:0]. Bias i uses lane i%8.
- FSM states: IDLE, FETCH, LOAD, DRAIN, FIN.
- IDLE:
  - start with NUM_BIAS>0: set rom_addr_a=0, rom_addr_b=1, go to FETCH.
  - start with NUM_BIAS==0: go to FIN.
  - start while not in IDLE is ignored.
- FETCH: wait one cycle for the ROM's registered read, then go to LOAD.
- LOAD:
  - Capture {rom_q_a, rom_q_b} into a 256-bit buffer. Word 0 is rom_q_a[127:112]; word 15 is rom_q_b[15:0].
  - Go to DRAIN.
- DRAIN:
  - Present the current buffer word with bias_valid=1.
  - Advance only when bias_valid and bias_ready are both high.
  - bias_data, bias_idx and bias_last hold stable while bias_ready is low.
- End of a row pair (handshake on buffer word 15, index below NUM_BIAS-1):
  - Add 2 to both addresses.
  - Clamp rom_addr_b to DEPTH-1 if it would exceed it; words past NUM_BIAS are never emitted.
  - Go to FETCH, so bias_valid is low for 2 cycles.
- Handshake on index NUM_BIAS-1: drop bias_valid next cycle and go to FIN. This can fall mid-buffer.
- FIN: pulse done for 1 cycle, then go to IDLE.
- Throughput without the optional feature: 16 words per 18 cycles, assuming ready is always high.
- Latency: start to first bias_valid is 3 cycles (FETCH, LOAD, then valid in DRAIN).
- Address arithmetic wraps at ADDR_WIDTH bits. The clamp keeps addresses inside DEPTH.

Optional Feature:
BIAS_SEQ_PREFETCH_EN
- Defined:
  - Add a second 256-bit shadow buffer.
  - On entering DRAIN, if rows remain, issue the next pair address. The shadow buffer captures it 2 cycles later and is marked full.
  - On the handshake of word 15, if the shadow is full it becomes current and DRAIN continues with no bubble.
  - If the shadow is not yet full, the sequencer waits in DRAIN with valid low until capture completes.
  - Steady-state throughput is 1 word/cycle.
  - Start latency is unchanged at 3 cycles.
- Undefined: behaviour is as in Behaviour above.

Test Plan:
- Reset then start, ready always high:
  - idx 0 = 0xFED4, idx 7 = 0x02C8, idx 8 = 0xFF3C, idx 15 = 0x0009, idx 16 = 0xFF67.
  - 122 words total; bias_last only on idx 121 = 0xF5C1; idx 120 = 0x0418.
  - done exactly 1 cycle after the last handshake.
- Address sequence: pairs (0,1), (2,3), … (14,15) are each issued once.
  - 8 fetches.
  - Without PREFETCH, a 2-cycle valid gap after idx 15, 31, … 111.
- Backpressure: hold ready low for 5 cycles while idx 9 (0xFF65) is presented.
  - data/idx stay stable.
  - No word is skipped or duplicated.
  - Next accepted is idx 10 = 0x004E.
- start asserted while busy, at idx 40: ignored; the stream and count are unchanged.
- rst asserted at idx 60:
  - All outputs 0 immediately.
  - A later start restarts at idx 0 = 0xFED4.
  - No stale done.
- PREFETCH_EN, ready always high: 122 consecutive valid cycles with no gap. Same values as the first scenario.

Source files
------------

// File: rtl/bias_seq_ctrl_if.sv
// rtl/bias_seq_ctrl_if.sv - control, ROM and bias-stream bundle for bias_seq_ctrl
// Purpose : groups the sequencer's run control, ROM ports and bias stream.
// Signals : start/busy/done run control; rom_addr_a/rom_addr_b with rom_q_a/rom_q_b
//           for the dual-port ROM; bias_data/bias_idx/bias_valid/bias_ready/bias_last
//           for the bias stream.
// Modports: master = sequencer side, slave = ROM/consumer/control side.
interface bias_seq_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 128,
  parameter int IDX_WIDTH  = 7
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] rom_addr_a;
  logic [ADDR_WIDTH-1:0] rom_addr_b;
  logic [DATA_WIDTH-1:0] rom_q_a;
  logic [DATA_WIDTH-1:0] rom_q_b;
  logic [15:0]           bias_data;
  logic [IDX_WIDTH-1:0]  bias_idx;
  logic                  bias_valid;
  logic                  bias_ready;
  logic                  bias_last;

  modport master (
    input  start, rom_q_a, rom_q_b, bias_ready,
    output busy, done, rom_addr_a, rom_addr_b, bias_data, bias_idx, bias_valid, bias_last
  );

  modport slave (
    output start, rom_q_a, rom_q_b, bias_ready,
    input  busy, done, rom_addr_a, rom_addr_b, bias_data, bias_idx, bias_valid, bias_last
  );
endinterface

// File: rtl/bias_seq_ctrl.sv
// rtl/bias_seq_ctrl.sv - bias ROM sequencer streaming row-pair biases over valid/ready
// Purpose : on start, fetches ROM rows in even/odd pairs (port A even, port B odd),
//           unpacks eight signed 16-bit lanes per row and streams NUM_BIAS biases.
// Ports   : clk - clock; rst - asynchronous active-high reset
//           bus (master) - start/busy/done, rom_addr_a/b, rom_q_a/b,
//                          bias_data/bias_idx/bias_valid/bias_ready/bias_last
// Option  : BIAS_SEQ_PREFETCH_EN - shadow row-pair buffer for gapless streaming.
module bias_seq_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 128,
  parameter int NUM_BIAS   = 122,
  parameter int IDX_WIDTH  = 7
) (
  input logic             clk,
  input logic             rst,
  bias_seq_ctrl_if.master bus
);
  localparam int                    BUF_W      = 2 * DATA_WIDTH;
  localparam int                    LAST_INT   = (NUM_BIAS > 0) ? NUM_BIAS - 1 : 0;
  localparam logic [IDX_WIDTH-1:0]  LP_LAST    = IDX_WIDTH'(LAST_INT);
  localparam logic [IDX_WIDTH-1:0]  LP_IDX_ONE = IDX_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   LP_TWO     = (ADDR_WIDTH + 1)'(2);
  localparam logic [ADDR_WIDTH:0]   LP_MAX_B   = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [3:0]            LP_WLAST   = 4'(BUF_W / 16 - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, DRAIN, FIN} state_t;

  state_t                r_state;
  logic [BUF_W-1:0]      r_buf;
  logic [3:0]            r_wptr;
  logic [ADDR_WIDTH-1:0] r_addr_a;
  logic [ADDR_WIDTH-1:0] r_addr_b;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_valid;
  logic                  r_last;
  logic [15:0]           r_data;
  logic [IDX_WIDTH-1:0]  r_idx;

  logic [BUF_W-1:0]      w_q;
  logic [ADDR_WIDTH:0]   w_sum_b;
  logic [ADDR_WIDTH-1:0] w_next_a;
  logic [ADDR_WIDTH-1:0] w_next_b;
  logic [IDX_WIDTH-1:0]  w_idx_inc;
  logic                  w_hs;
  logic                  w_is_last;
  logic                  w_end_buf;
  logic                  w_resume;

  // Word 0 is the top lane of port A; word 15 is the bottom lane of port B.
  function automatic logic [15:0] f_word(input logic [BUF_W-1:0] b, input logic [3:0] k);
    f_word = b[(BUF_W - 1) - 16 * int'(k) -: 16];
  endfunction

  assign w_q       = {bus.rom_q_a, bus.rom_q_b};
  assign w_next_a  = r_addr_a + ADDR_WIDTH'(2);
  // Odd-row address is computed one bit wider so the clamp sees overflow past DEPTH-1.
  assign w_sum_b   = {1'b0, r_addr_b} + LP_TWO;
  assign w_next_b  = (w_sum_b > LP_MAX_B) ? LP_MAX_B[ADDR_WIDTH-1:0] : w_sum_b[ADDR_WIDTH-1:0];
  assign w_idx_inc = r_idx + LP_IDX_ONE;
  assign w_hs      = r_valid & bus.bias_ready;
  assign w_is_last = (r_idx == LP_LAST);
  assign w_end_buf = (r_wptr == LP_WLAST);

`ifdef BIAS_SEQ_PREFETCH_EN
  localparam int                PW     = ADDR_WIDTH + 5;
  localparam logic [PW-1:0]     LP_NUM = PW'(NUM_BIAS);
  logic [BUF_W-1:0]             r_shadow;
  logic                         r_sh_full;
  logic                         r_wait;
  logic [1:0]                   r_pf_pipe;   // [0]: address issued, [1]: ROM data ready
  logic [PW-1:0]                w_next_base;
  logic                         w_more;
  logic [IDX_WIDTH-1:0]         w_idx_nxt;

  // First bias index held by the pair after the one at r_addr_a.
  assign w_next_base = ({5'b0, r_addr_a} + PW'(2)) << 3;
  assign w_more      = (w_next_base < LP_NUM);
  assign w_resume    = r_wait;
  // While waiting the index was already advanced by the word-15 handshake.
  assign w_idx_nxt   = r_wait ? r_idx : w_idx_inc;
`else
  assign w_resume    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_buf     <= '0;
      r_wptr    <= '0;
      r_addr_a  <= '0;
      r_addr_b  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_data    <= '0;
      r_idx     <= '0;
`ifdef BIAS_SEQ_PREFETCH_EN
      r_shadow  <= '0;
      r_sh_full <= 1'b0;
      r_wait    <= 1'b0;
      r_pf_pipe <= '0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef BIAS_SEQ_PREFETCH_EN
      r_pf_pipe <= {r_pf_pipe[0], 1'b0};
      if (r_pf_pipe[1]) begin
        r_shadow  <= w_q;
        r_sh_full <= 1'b1;
      end
`endif
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_busy <= 1'b1;
            r_idx  <= '0;
            r_wptr <= '0;
            r_last <= 1'b0;
`ifdef BIAS_SEQ_PREFETCH_EN
            r_sh_full <= 1'b0;
            r_wait    <= 1'b0;
`endif
            if (NUM_BIAS > 0) begin
              r_addr_a <= '0;
              r_addr_b <= ADDR_WIDTH'(1);
              r_state  <= FETCH;
            end else begin
              r_done  <= 1'b1;
              r_state <= FIN;
            end
          end
        end
        FETCH: r_state <= LOAD;
        LOAD: begin
          r_buf   <= w_q;
          r_wptr  <= '0;
          r_data  <= f_word(w_q, 4'd0);
          r_valid <= 1'b1;
          r_last  <= w_is_last;
          r_state <= DRAIN;
`ifdef BIAS_SEQ_PREFETCH_EN
          if (w_more) begin
            r_addr_a  <= w_next_a;
            r_addr_b  <= w_next_b;
            r_pf_pipe <= {r_pf_pipe[0], 1'b1};
          end
`endif
        end
        DRAIN: begin
          if (w_hs && w_is_last) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= FIN;
          end else if (w_hs && !w_end_buf) begin
            r_idx  <= w_idx_inc;
            r_wptr <= r_wptr + 4'd1;
            r_data <= f_word(r_buf, r_wptr + 4'd1);
            r_last <= (w_idx_inc == LP_LAST);
          end else if (w_hs || w_resume) begin
            if (w_hs) begin
              r_idx <= w_idx_inc;
            end
`ifdef BIAS_SEQ_PREFETCH_EN
            if (r_sh_full) begin
              r_buf     <= r_shadow;
              r_sh_full <= 1'b0;
              r_wait    <= 1'b0;
              r_wptr    <= '0;
              r_data    <= f_word(r_shadow, 4'd0);
              r_valid   <= 1'b1;
              r_last    <= (w_idx_nxt == LP_LAST);
              if (w_more) begin
                r_addr_a  <= w_next_a;
                r_addr_b  <= w_next_b;
                r_pf_pipe <= {r_pf_pipe[0], 1'b1};
              end
            end else begin
              r_valid <= 1'b0;
              r_wait  <= 1'b1;
            end
`else
            r_valid  <= 1'b0;
            r_addr_a <= w_next_a;
            r_addr_b <= w_next_b;
            r_state  <= FETCH;
`endif
          end
        end
        FIN: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.rom_addr_a = r_addr_a;
  assign bus.rom_addr_b = r_addr_b;
  assign bus.bias_data  = r_data;
  assign bus.bias_idx   = r_idx;
  assign bus.bias_valid = r_valid;
  assign bus.bias_last  = r_last;
endmodule

// File: tb/tb_bias_seq_ctrl.sv
// tb/tb_bias_seq_ctrl.sv - directed table-driven bench for bias_seq_ctrl
module tb_bias_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bias_seq_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(128), .IDX_WIDTH(7)) bus ();

  bias_seq_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  logic [15:0]  exp_w [128];
  logic [127:0] rom   [16];

  always @(posedge clk) begin
    bus.rom_q_a <= rom[bus.rom_addr_a];
    bus.rom_q_b <= rom[bus.rom_addr_b];
  end

  typedef struct {
    int          cyc;
    int          idx;
    logic [15:0] data;
    logic        last;
  } hs_t;

  typedef struct {
    int          idx;
    logic [15:0] data;
    logic        last;
  } vec_t;

  hs_t        hs_q [$];
  int         done_q [$];
  logic [7:0] addr_q [$];
  logic [7:0] prev_addr = 8'h00;
  vec_t       vecs [9];

  always @(negedge clk) begin
    if (bus.bias_valid && bus.bias_ready)
      hs_q.push_back('{cyc, int'(bus.bias_idx), bus.bias_data, bus.bias_last});
    if (bus.done) done_q.push_back(cyc);
    if (bus.busy && {bus.rom_addr_a, bus.rom_addr_b} != prev_addr)
      addr_q.push_back({bus.rom_addr_a, bus.rom_addr_b});
    prev_addr <= {bus.rom_addr_a, bus.rom_addr_b};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(output int scyc);
    @(posedge clk); #1;
    bus.start = 1'b1;
    scyc = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_pres(input int idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (bus.bias_valid && int'(bus.bias_idx) == idx) ok = 1'b1;
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (bus.done) ok = 1'b1;
    end
    @(negedge clk); #1;
  endtask

  // Full-run checks: 122 words in order with correct data/last, one done one cycle late.
  task automatic check_run(input string tag, input int base, input int dbase);
    int n;
    n = hs_q.size() - base;
    check({tag, "_count"}, n, 122);
    for (int i = 0; i < 122 && i < n; i++)
      check($sformatf("%s_w%0d", tag, i),
            {8'd0, 7'(hs_q[base+i].idx), hs_q[base+i].data, hs_q[base+i].last},
            {8'd0, 7'(i), exp_w[i], (i == 121) ? 1'b1 : 1'b0});
    check({tag, "_done_count"}, done_q.size() - dbase, 1);
    if (n > 0 && done_q.size() > dbase)
      check({tag, "_done_time"}, done_q[dbase], hs_q[hs_q.size()-1].cyc + 1);
  endtask

  task automatic check_fetches(input string tag, input int abase);
    int bad;
    bad = 0;
    check({tag, "_fetches"}, addr_q.size() - abase, 8);
    for (int k = 0; k < 8 && abase + k < addr_q.size(); k++)
      if (addr_q[abase+k] != {4'(2*k), 4'(2*k+1)}) bad++;
    check({tag, "_fetch_pairs_bad"}, bad, 0);
  endtask

  initial begin
    int  base, dbase, abase, scyc, bad, gap, expg;
    bit  ok;

    for (int i = 0; i < 128; i++) exp_w[i] = 16'(i * 2909 + 4660);
    exp_w[0]   = 16'hFED4;  exp_w[7]   = 16'h02C8;  exp_w[8]   = 16'hFF3C;
    exp_w[9]   = 16'hFF65;  exp_w[10]  = 16'h004E;  exp_w[15]  = 16'h0009;
    exp_w[16]  = 16'hFF67;  exp_w[120] = 16'h0418;  exp_w[121] = 16'hF5C1;
    for (int r = 0; r < 16; r++)
      for (int l = 0; l < 8; l++)
        rom[r][127 - 16*l -: 16] = exp_w[8*r + l];

    vecs[0] = '{0,   16'hFED4, 1'b0};
    vecs[1] = '{7,   16'h02C8, 1'b0};
    vecs[2] = '{8,   16'hFF3C, 1'b0};
    vecs[3] = '{9,   16'hFF65, 1'b0};
    vecs[4] = '{10,  16'h004E, 1'b0};
    vecs[5] = '{15,  16'h0009, 1'b0};
    vecs[6] = '{16,  16'hFF67, 1'b0};
    vecs[7] = '{120, 16'h0418, 1'b0};
    vecs[8] = '{121, 16'hF5C1, 1'b1};

    bus.start = 1'b0;
    bus.bias_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("reset_ctl", {20'd0, bus.busy, bus.done, bus.bias_valid, bus.bias_last,
                        bus.rom_addr_a, bus.rom_addr_b}, 32'd0);
    check("reset_data", {9'd0, bus.bias_idx, bus.bias_data}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Run 1: ready always high.
    bus.bias_ready = 1'b1;
    base = hs_q.size(); dbase = done_q.size(); abase = addr_q.size();
    pulse_start(scyc);
    wait_done(400, ok);
    check("run1_done_seen", ok, 1);
    check_run("run1", base, dbase);
    check_fetches("run1", abase);
    if (hs_q.size() > base) check("run1_latency", hs_q[base].cyc - scyc, 3);
    for (int v = 0; v < 9; v++)
      if (base + vecs[v].idx < hs_q.size())
        check($sformatf("vec_idx%0d", vecs[v].idx),
              {15'd0, hs_q[base+vecs[v].idx].data, hs_q[base+vecs[v].idx].last},
              {15'd0, vecs[v].data, vecs[v].last});
    bad = 0;
    for (int i = 0; i + 1 < 122 && base + i + 1 < hs_q.size(); i++) begin
      gap = hs_q[base+i+1].cyc - hs_q[base+i].cyc;
`ifdef BIAS_SEQ_PREFETCH_EN
      expg = 1;
`else
      expg = (i % 16 == 15) ? 3 : 1;
`endif
      if (gap != expg) bad++;
    end
    check("run1_gaps_bad", bad, 0);
    @(posedge clk); #1;
    check("run1_busy_after", bus.busy, 0);

    // Run 2: backpressure on idx 9, ignored start at idx 40.
    base = hs_q.size(); dbase = done_q.size(); abase = addr_q.size();
    pulse_start(scyc);
    wait_pres(9, 50, ok);
    check("bp_reach9", ok, 1);
    bus.bias_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", k),
            {7'd0, bus.bias_valid, bus.bias_idx, bus.bias_data, bus.bias_last},
            {7'd0, 1'b1, 7'd9, 16'hFF65, 1'b0});
    end
    @(posedge clk); #1;
    bus.bias_ready = 1'b1;
    wait_pres(40, 100, ok);
    check("busy_reach40", ok, 1);
    check("busy_mid_run", bus.busy, 1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(400, ok);
    check("run2_done_seen", ok, 1);
    check_run("run2", base, dbase);
    check_fetches("run2", abase);
    if (base + 10 < hs_q.size())
      check("bp_next", {9'd0, 7'(hs_q[base+10].idx), hs_q[base+10].data},
            {9'd0, 7'd10, 16'h004E});

    // Run 3: reset at idx 60, then restart.
    dbase = done_q.size();
    pulse_start(scyc);
    wait_pres(60, 200, ok);
    check("rst_reach60", ok, 1);
    rst = 1'b1;
    #1;
    check("midrst_ctl", {20'd0, bus.busy, bus.done, bus.bias_valid, bus.bias_last,
                         bus.rom_addr_a, bus.rom_addr_b}, 32'd0);
    check("midrst_data", {9'd0, bus.bias_idx, bus.bias_data}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_done", done_q.size() - dbase, 0);
    check("midrst_idle", {bus.busy, bus.bias_valid}, 2'b00);

    base = hs_q.size(); dbase = done_q.size();
    pulse_start(scyc);
    wait_pres(0, 20, ok);
    check("restart_first_seen", ok, 1);
    check("restart_latency", cyc - scyc, 3);
    check("restart_word0", {9'd0, bus.bias_idx, bus.bias_data}, {9'd0, 7'd0, 16'hFED4});
    wait_done(400, ok);
    check("run4_done_seen", ok, 1);
    check_run("run4", base, dbase);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
